ppu_delay_pipe: RTL and testbench

- Parameterised register delay line, DATA_WIDTH bits wide and PIPE_DEPTH stages deep.
- Used by the PPU wrapper to retime the bundled PPU inputs in front of the core, split as {in_valid, op, operand1, operand2, operand3}.
- Also used to retime the bundled PPU outputs {result, out_valid} behind the core.
- Carries opaque data with no interpretation; valid bits travel as ordinary data bits.

---
 rtl/ppu_delay_pipe_pkg.sv | 24 ++
 rtl/ppu_delay_pipe_if.sv | 11 +
 rtl/ppu_delay_pipe_stage.sv | 31 +++
 rtl/ppu_delay_pipe.sv | 47 ++++
 tb/tb_ppu_delay_pipe.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ppu_delay_pipe_pkg.sv
// Local definitions for the PPU retiming delay line: depth limits and the
// structural mode chosen from the configured depth.
package ppu_delay_pipe_pkg;

  // Deepest delay line a caller may request.
  localparam int unsigned MAX_PIPE_DEPTH = 64;

  // A zero-depth line is a plain wire; anything deeper is a register chain.
  typedef enum logic {
    PIPE_WIRE = 1'b0,
    PIPE_REG  = 1'b1
  } pipe_mode_e;

  // Map a requested depth onto the structure that implements it.
  function automatic pipe_mode_e pipe_mode(input int unsigned depth);
    return (depth == 0) ? PIPE_WIRE : PIPE_REG;
  endfunction

  // True when the depth lies in the supported range.
  function automatic bit depth_legal(input int unsigned depth);
    return depth <= MAX_PIPE_DEPTH;
  endfunction

endpackage

// File: rtl/ppu_delay_pipe_if.sv
// Bundle carried through the delay line: the word going in and the
// retimed word coming out. The master drives the input side.
interface ppu_delay_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (output data_in, input data_out);
  modport slave  (input data_in, output data_out);
endinterface

// File: rtl/ppu_delay_pipe_stage.sv
// One stage of the delay line: a DATA_WIDTH register cleared to zero
// asynchronously while the active-low reset is held.
module ppu_delay_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Next state is simply the upstream word; the stage never holds.
  always_comb begin
    data_d = d_i;
  end

  // Capture every rising edge; clear immediately when reset falls.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ppu_delay_pipe.sv
// Register delay line of PIPE_DEPTH stages used to retime the bundled PPU
// inputs and outputs. The word is opaque; embedded valid bits are delayed
// exactly like their payload and read zero after reset.
module ppu_delay_pipe
  import ppu_delay_pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam pipe_mode_e MODE = pipe_mode(PIPE_DEPTH);
  localparam bit         LEGAL = depth_legal(PIPE_DEPTH);

  // Out-of-range depths are a caller error; flag them in simulation.
  initial_check : assert property (@(posedge clk_i) LEGAL && (DATA_WIDTH >= 1));

  generate
    if (MODE == PIPE_WIRE) begin : g_wire
      // Zero depth: straight combinational path, clock and reset unused.
      assign data_out = data_in;
    end else begin : g_regs
      // chain[0] is the incoming word, chain[k] the output of stage k.
      logic [DATA_WIDTH-1:0] chain [0:PIPE_DEPTH];

      assign chain[0] = data_in;

      for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
        ppu_delay_stage #(
          .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
          .clk_i (clk_i),
          .rst_i (rst_i),
          .d_i   (chain[g]),
          .q_o   (chain[g+1])
        );
      end

      assign data_out = chain[PIPE_DEPTH];
    end
  endgenerate

endmodule

// File: tb/tb_ppu_delay_pipe.sv
// Bench for ppu_delay_pipe: five instances at the configurations of the
// test plan, a queue-based reference model per instance, a per-cycle
// compare process and a set of literal expectations.
module tb_ppu_delay_pipe;

  localparam int WA = 8;   localparam int DA = 3;
  localparam int WB = 8;   localparam int DB = 0;
  localparam int WC = 8;   localparam int DC = 2;
  localparam int WD = 53;  localparam int DD = 1;
  localparam int WE = 32;  localparam int DE = 1;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0, rst_e = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ppu_delay_pipe_if #(.DATA_WIDTH(WA)) if_a ();
  ppu_delay_pipe_if #(.DATA_WIDTH(WB)) if_b ();
  ppu_delay_pipe_if #(.DATA_WIDTH(WC)) if_c ();
  ppu_delay_pipe_if #(.DATA_WIDTH(WD)) if_d ();
  ppu_delay_pipe_if #(.DATA_WIDTH(WE)) if_e ();

  ppu_delay_pipe #(.PIPE_DEPTH(DA), .DATA_WIDTH(WA)) u_a (
    .clk_i(clk), .rst_i(rst_a), .data_in(if_a.data_in), .data_out(if_a.data_out));
  ppu_delay_pipe #(.PIPE_DEPTH(DB), .DATA_WIDTH(WB)) u_b (
    .clk_i(clk), .rst_i(rst_b), .data_in(if_b.data_in), .data_out(if_b.data_out));
  ppu_delay_pipe #(.PIPE_DEPTH(DC), .DATA_WIDTH(WC)) u_c (
    .clk_i(clk), .rst_i(rst_c), .data_in(if_c.data_in), .data_out(if_c.data_out));
  ppu_delay_pipe #(.PIPE_DEPTH(DD), .DATA_WIDTH(WD)) u_d (
    .clk_i(clk), .rst_i(rst_d), .data_in(if_d.data_in), .data_out(if_d.data_out));
  ppu_delay_pipe #(.PIPE_DEPTH(DE), .DATA_WIDTH(WE)) u_e (
    .clk_i(clk), .rst_i(rst_e), .data_in(if_e.data_in), .data_out(if_e.data_out));

  // Reference model: history of words accepted since the last reset.
  logic [63:0] qa[$], qc[$], qd[$], qe[$];

  function automatic logic [63:0] model_out(input logic [63:0] q[$], input int depth);
    if (q.size() < depth) return 64'd0;
    return q[q.size() - depth];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_a)
    if (!rst_a) qa.delete();
    else begin qa.push_back(64'(if_a.data_in)); if (qa.size() > 80) void'(qa.pop_front()); end
  always @(posedge clk or negedge rst_c)
    if (!rst_c) qc.delete();
    else begin qc.push_back(64'(if_c.data_in)); if (qc.size() > 80) void'(qc.pop_front()); end
  always @(posedge clk or negedge rst_d)
    if (!rst_d) qd.delete();
    else begin qd.push_back(64'(if_d.data_in)); if (qd.size() > 80) void'(qd.pop_front()); end
  always @(posedge clk or negedge rst_e)
    if (!rst_e) qe.delete();
    else begin qe.push_back(64'(if_e.data_in)); if (qe.size() > 80) void'(qe.pop_front()); end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    check("model_a", 64'(if_a.data_out), model_out(qa, DA));
    check("model_b", 64'(if_b.data_out), 64'(if_b.data_in));
    check("model_c", 64'(if_c.data_out), model_out(qc, DC));
    check("model_d", 64'(if_d.data_out), model_out(qd, DD));
    check("model_e", 64'(if_e.data_out), model_out(qe, DE));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [7:0]  lat_in  [0:6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
  logic [7:0]  lat_exp [0:6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
  logic [52:0] bundle;

  initial begin
    if_a.data_in = '0; if_b.data_in = '0; if_c.data_in = '0;
    if_d.data_in = '0; if_e.data_in = '0;

    // Reset hold: all-ones input with reset asserted for five cycles.
    if_a.data_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_hold_a", 64'(if_a.data_out), 64'h00);
    end
    check("reset_hold_c", 64'(if_c.data_out), 64'h00);
    check("reset_hold_d_valid", 64'(if_d.data_out[52]), 64'h0);

    // Passthrough: combinational, reset has no effect.
    if_b.data_in = 8'hA5;
    #1;
    check("pass_rst_low", 64'(if_b.data_out), 64'hA5);
    rst_b = 1'b1;
    #1;
    check("pass_rst_high", 64'(if_b.data_out), 64'hA5);
    rst_b = 1'b0;
    if_b.data_in = 8'h3C;
    #1;
    check("pass_new_value", 64'(if_b.data_out), 64'h3C);

    // Release the registered instances between edges.
    if_a.data_in = '0;
    rst_a = 1'b1; rst_c = 1'b1; rst_d = 1'b1; rst_e = 1'b1;

    // Latency: depth 3, 0x11..0x44 on consecutive edges.
    for (int k = 0; k < 7; k++) begin
      if_a.data_in = lat_in[k];
      step();
      check("latency_a", 64'(if_a.data_out), 64'(lat_exp[k]));
    end

    // Async reset mid-stream on the depth-2 instance.
    for (int k = 1; k <= 5; k++) begin
      if_c.data_in = 8'(k);
      step();
    end
    check("stream_c", 64'(if_c.data_out), 64'h04);
    #1;
    rst_c = 1'b0;
    #1;
    check("async_clear_c", 64'(if_c.data_out), 64'h00);
    step();
    check("held_clear_c", 64'(if_c.data_out), 64'h00);
    #1;
    rst_c = 1'b1;
    if_c.data_in = 8'h77;
    step();
    if_c.data_in = 8'h00;
    check("post_reset_c_e1", 64'(if_c.data_out), 64'h00);
    step();
    check("post_reset_c_e2", 64'(if_c.data_out), 64'h77);
    step();
    check("post_reset_c_e3", 64'(if_c.data_out), 64'h00);

    // Valid bundling: one valid word, then idle.
    bundle = {1'b1, 4'h3, 16'h1234, 16'h5678, 16'h9ABC};
    if_d.data_in = bundle;
    step();
    if_d.data_in = '0;
    check("bundle_word", 64'(if_d.data_out), 64'h1_3123_4567_89ABC);
    check("bundle_valid", 64'(if_d.data_out[52]), 64'h1);
    step();
    check("bundle_valid_drop", 64'(if_d.data_out[52]), 64'h0);

    // Depth-1 back-to-back alternation.
    for (int k = 0; k < 8; k++) begin
      if_e.data_in = (k % 2 == 0) ? 32'hDEADBEEF : 32'h00000000;
      step();
      check("alternate_e", 64'(if_e.data_out),
            (k % 2 == 0) ? 64'hDEADBEEF : 64'h0);
    end
    if_e.data_in = '0;

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
